seg7_scan: RTL and testbench
============================

# seg7_scan

Time-multiplexed 4-digit hexadecimal seven-segment driver that sits directly downstream of the CPU core inside `Top` and produces the board-level `Segment`/`AN` pins. It captures a 32-bit word from the core's data-hold path on a write strobe, shows either half of it as four hex digits, and scans the digits with a programmable refresh divider. It also provides leading-zero blanking, per-digit decimal points and a frame-complete pulse.

## Interface

Parameters:
- `SCAN_DIV`, default 50000. Clock cycles each digit stays enabled. Legal range is 2 to 2^20.

Ports:
- `clk`  input  1  System clock. All state updates on the rising edge.
- `reset`  input  1  One clock; reset is synchronous and active-high.
- `data_in`  input  32  Word to display, sampled when `data_we`=1.
- `data_we`  input  1  Capture strobe. Loads `data_in` into the hold register on this edge.
- `page`  input  1  Half select. 0 shows hold[15:0]; 1 shows hold[31:16].
- `dp_in`  input  4  Decimal-point request per digit, active-high. Bit i maps to digit i.
- `blank_lz`  input  1  1 enables leading-zero suppression.
- `Segment`  output  8  Segment pins, active-low, registered. [7]=dp, [6:0]=g..a.
- `AN`  output  4  Digit enables, active-low, registered. AN[0] is the rightmost digit, i.e. the least-significant nibble.
- `data_hold`  output  32  Current hold register, for the debug path.
- `frame_done`  output  1  One-cycle pulse per completed 4-digit frame.

## Operation

- Hold register:
  - `data_hold` <= `data_in` on any edge with `data_we`=1.
  - Otherwise it keeps its value.
- Divider `cnt`:
  - Counts 0 to SCAN_DIV-1.
  - At SCAN_DIV-1 it wraps to 0 and digit index `idx` increments mod 4 (3 wraps to 0).
- Displayed nibble `n` = selected half[4*idx+3 : 4*idx].
- Hex decode, active-low g..a:
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000
  - 4=0011001, 5=0010010, 6=0000010, 7=1111000
  - 8=0000000, 9=0010000, A=0001000, b=0000011
  - C=1000110, d=0100001, E=0000110, F=0001110
- `Segment[7]` = ~dp_in[idx].
- Blanking:
  - Digit i (i≥1) is blank when `blank_lz`=1 and every nibble from i up to 3 of the selected half is zero.
  - Digit 0 is never blank.
  - A blank digit drives AN=4'b1111 and Segment=8'hFF, regardless of `dp_in`.
- Non-blank digit: AN = one-hot-low of idx, Segment = {~dp_in[idx], decode(n)}.
- Reset has priority over everything, including `data_we`. Reset clears:
  - hold to 0
  - cnt to 0
  - idx to 0
  - AN to 4'b1111
  - Segment to 8'hFF
  - frame_done to 0
- Reset asserted mid-frame: outputs go dark on that edge. Scanning restarts from digit 0 after release.

## Timing

- `AN` and `Segment` are registered from the current idx, hold, `page`, `dp_in` and `blank_lz`. Any input change therefore appears at the pins one edge later.
- First edge after reset release: AN=4'b1110, Segment shows nibble 0.
- Each digit is then enabled for exactly SCAN_DIV consecutive cycles. A full frame is 4*SCAN_DIV cycles.
- `data_we` at edge k updates `data_hold` at edge k. The pins reflect the new value at edge k+1, mid-digit if necessary; the scan phase is not disturbed.
- `frame_done` is high for the single cycle in which AN first returns to digit 0 after digit 3.
- No pulse is produced for the first frame after reset.
- Back-to-back `data_we`: the last-written word wins. No holding off or backpressure.

## Test plan

- Reset behaviour (SCAN_DIV=4): hold reset 5 cycles → AN=1111, Segment=FF, data_hold=0. After release → AN sequence 1110,1101,1011,0111, 4 cycles each, repeating; `frame_done` pulses once per 16 cycles, starting with the second frame.
- Decode and paging: write 0x1234ABCD, page=0 → digits 0..3 show Segment 8'hA1, 8'hC6, 8'h83, 8'h88. Set page=1 → digits 0..3 show 8'h99, 8'hB0, 8'hA4, 8'hF9.
- Leading-zero blanking: write 0x00000050, blank_lz=1 → digits 2 and 3 stay AN=1111 / Segment=FF, digit 1 shows 8'h92, digit 0 shows 8'hC0. Write 0 → only digit 0 lit, showing 8'hC0.
- Decimal points and blanking precedence: dp_in=4'b0101, value 0x8888 → digits 0 and 2 show 8'h00, digits 1 and 3 show 8'h80. With value 0x0008 and blank_lz=1, digit 2 stays blank despite dp_in[2]=1.
- Capture and reset priority: `data_we` and `reset` asserted on the same edge → data_hold=0. A mid-digit `data_we` changes Segment exactly one edge later while AN holds its current digit.
- Reset mid-frame: assert reset while digit 2 is active → dark on the same edge. After release, scan restarts at digit 0 with a full SCAN_DIV dwell.

Source files
------------

// File: rtl/seg7_scan.sv
// Four-digit multiplexed hex seven-segment driver: holds a 32-bit word,
// shows one 16-bit half, scans digits with a programmable dwell per digit.
module seg7_scan #(
    parameter int SCAN_DIV = 50000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] data_in,
    input  logic        data_we,
    input  logic        page,
    input  logic [3:0]  dp_in,
    input  logic        blank_lz,
    output logic [7:0]  Segment,
    output logic [3:0]  AN,
    output logic [31:0] data_hold,
    output logic        frame_done
);

    localparam int CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(SCAN_DIV - 1);

    logic [CNT_W-1:0] cnt;
    logic [1:0]       idx;
    logic             wrapped;

    logic             last_tick;
    logic [15:0]      half;
    logic [3:0]       nibble;
    logic             digit_blank;
    logic [6:0]       seg_code;
    logic [7:0]       seg_next;
    logic [3:0]       an_next;
    logic             frame_next;

    function automatic logic [6:0] hex_decode(input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'h0:    s = 7'b1000000;
            4'h1:    s = 7'b1111001;
            4'h2:    s = 7'b0100100;
            4'h3:    s = 7'b0110000;
            4'h4:    s = 7'b0011001;
            4'h5:    s = 7'b0010010;
            4'h6:    s = 7'b0000010;
            4'h7:    s = 7'b1111000;
            4'h8:    s = 7'b0000000;
            4'h9:    s = 7'b0010000;
            4'hA:    s = 7'b0001000;
            4'hB:    s = 7'b0000011;
            4'hC:    s = 7'b1000110;
            4'hD:    s = 7'b0100001;
            4'hE:    s = 7'b0000110;
            default: s = 7'b0001110;
        endcase
        return s;
    endfunction

    always_comb begin
        last_tick = (cnt == CNT_MAX);
        half      = page ? data_hold[31:16] : data_hold[15:0];
        nibble    = 4'(half >> {idx, 2'b00});

        // A digit is a leading zero only if it and everything above it is zero.
        digit_blank = 1'b0;
        case (idx)
            2'd1:    digit_blank = blank_lz && (half[15:4] == 12'h000);
            2'd2:    digit_blank = blank_lz && (half[15:8] == 8'h00);
            2'd3:    digit_blank = blank_lz && (half[15:12] == 4'h0);
            default: digit_blank = 1'b0;
        endcase

        seg_code = hex_decode(nibble);
        if (digit_blank) begin
            seg_next = 8'hFF;
            an_next  = 4'b1111;
        end else begin
            seg_next = {~dp_in[idx], seg_code};
            an_next  = ~(4'b0001 << idx);
        end

        // Pins lag idx by one edge, so digit 0 appears at the pins on the
        // edge where idx/cnt sit at the very start of digit 0.
        frame_next = wrapped && (idx == 2'd0) && (cnt == '0);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            data_hold  <= 32'h0;
            cnt        <= '0;
            idx        <= 2'd0;
            wrapped    <= 1'b0;
            AN         <= 4'b1111;
            Segment    <= 8'hFF;
            frame_done <= 1'b0;
        end else begin
            if (data_we) begin
                data_hold <= data_in;
            end
            if (last_tick) begin
                cnt <= '0;
                idx <= idx + 2'd1;
                if (idx == 2'd3) begin
                    wrapped <= 1'b1;
                end
            end else begin
                cnt <= cnt + 1'b1;
            end
            AN         <= an_next;
            Segment    <= seg_next;
            frame_done <= frame_next;
        end
    end

endmodule

// File: tb/tb_seg7_scan.sv
// Randomised scoreboard bench for seg7_scan: a time-based reference model
// predicts the pins every edge; a negedge monitor pops and compares.
module tb_seg7_scan;

    localparam int D = 4;

    logic        clk;
    logic        reset;
    logic [31:0] data_in;
    logic        data_we;
    logic        page;
    logic [3:0]  dp_in;
    logic        blank_lz;
    logic [7:0]  Segment;
    logic [3:0]  AN;
    logic [31:0] data_hold;
    logic        frame_done;

    int n_tests = 0;
    int n_fail  = 0;

    // {AN[3:0], Segment[7:0], frame_done, data_hold[31:0]}
    logic [44:0] exp_q[$];

    seg7_scan #(.SCAN_DIV(D)) dut (
        .clk        (clk),
        .reset      (reset),
        .data_in    (data_in),
        .data_we    (data_we),
        .page       (page),
        .dp_in      (dp_in),
        .blank_lz   (blank_lz),
        .Segment    (Segment),
        .AN         (AN),
        .data_hold  (data_hold),
        .frame_done (frame_done)
    );

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // reference model: pins follow elapsed time since reset release
    logic [6:0] seg_tab [16];
    initial begin
        seg_tab[0]  = 7'b1000000; seg_tab[1]  = 7'b1111001;
        seg_tab[2]  = 7'b0100100; seg_tab[3]  = 7'b0110000;
        seg_tab[4]  = 7'b0011001; seg_tab[5]  = 7'b0010010;
        seg_tab[6]  = 7'b0000010; seg_tab[7]  = 7'b1111000;
        seg_tab[8]  = 7'b0000000; seg_tab[9]  = 7'b0010000;
        seg_tab[10] = 7'b0001000; seg_tab[11] = 7'b0000011;
        seg_tab[12] = 7'b1000110; seg_tab[13] = 7'b0100001;
        seg_tab[14] = 7'b0000110; seg_tab[15] = 7'b0001110;
    end

    initial begin
        logic [31:0] m_hold;
        int          t;
        int          d;
        int          half;
        int          nib;
        bit          blank;
        bit          fd;
        logic [3:0]  an_e;
        logic [7:0]  seg_e;
        m_hold = 32'h0;
        t = 0;
        forever begin
            @(posedge clk);
            if (reset) begin
                m_hold = 32'h0;
                t = 0;
                exp_q.push_back({4'hF, 8'hFF, 1'b0, 32'h0});
            end else begin
                half  = page ? int'(m_hold[31:16]) : int'(m_hold[15:0]);
                d     = (t / D) % 4;
                nib   = (half >> (4 * d)) % 16;
                blank = blank_lz && (d != 0) && ((half >> (4 * d)) == 0);
                if (blank) begin
                    an_e  = 4'hF;
                    seg_e = 8'hFF;
                end else begin
                    an_e  = ~(4'(1 << d));
                    seg_e = {~dp_in[d], seg_tab[nib]};
                end
                fd = (t >= 4 * D) && (t % (4 * D) == 0);
                if (data_we) m_hold = data_in;
                exp_q.push_back({an_e, seg_e, fd, m_hold});
                t++;
            end
        end
    end

    // scoreboard monitor
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    initial begin
        logic [44:0] e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("AN", 32'(AN), 32'(e[44:41]));
                check("Segment", 32'(Segment), 32'(e[40:33]));
                check("frame_done", 32'(frame_done), 32'(e[32]));
                check("data_hold", data_hold, e[31:0]);
            end
        end
    end

    // driver tasks
    task automatic cycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic write_word(input logic [31:0] w);
        data_in = w;
        data_we = 1'b1;
        cycles(1);
        data_we = 1'b0;
    endtask

    function automatic logic [31:0] sparse_word();
        logic [31:0] w;
        w = $urandom;
        for (int i = 0; i < 8; i++) begin
            if ($urandom_range(0, 1) == 0) w[4*i +: 4] = 4'h0;
        end
        return w;
    endfunction

    initial begin
        reset    = 1'b1;
        data_in  = 32'hDEADBEEF;
        data_we  = 1'b0;
        page     = 1'b0;
        dp_in    = 4'b0000;
        blank_lz = 1'b0;

        cycles(5);
        reset = 1'b0;
        cycles(40);

        write_word(32'h1234ABCD);
        cycles(16);
        page = 1'b1;
        cycles(16);
        page = 1'b0;

        blank_lz = 1'b1;
        write_word(32'h00000050);
        cycles(16);
        write_word(32'h00000000);
        cycles(16);

        blank_lz = 1'b0;
        dp_in = 4'b0101;
        write_word(32'h00008888);
        cycles(16);
        blank_lz = 1'b1;
        write_word(32'h00000008);
        cycles(16);

        // capture collides with reset
        reset = 1'b1;
        data_in = 32'hCAFEF00D;
        data_we = 1'b1;
        cycles(1);
        reset = 1'b0;
        data_we = 1'b0;
        cycles(2);
        // mid-digit capture
        write_word(32'h0000F00D);
        cycles(D + 2);
        write_word(32'h00001234);
        cycles(8);

        // reset while digit 2 is showing
        reset = 1'b1;
        cycles(1);
        reset = 1'b0;
        cycles(2 * D + 1);
        reset = 1'b1;
        cycles(1);
        reset = 1'b0;
        cycles(20);

        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 5) == 0) begin
                data_in = sparse_word();
                data_we = 1'b1;
            end else begin
                data_we = 1'b0;
            end
            if ($urandom_range(0, 15) == 0) page = ~page;
            if ($urandom_range(0, 15) == 0) blank_lz = ~blank_lz;
            if ($urandom_range(0, 7) == 0) dp_in = 4'($urandom);
            reset = ($urandom_range(0, 99) == 0);
            cycles(1);
        end
        data_we = 1'b0;
        reset   = 1'b0;
        cycles(3);

        @(negedge clk);
        #1;
        n_tests++;
        if (exp_q.size() > 1) begin
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d pending expected at most 1", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
